l1_prefetch_issue_ctrl: RTL
===========================

L1_PREFETCH_ISSUE_CTRL -- requirements
Module: l1_prefetch_issue_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 40, physical address width.
REQ-002 SHALL have parameter LINE_SHIFT, default 6, log2 cache-line bytes.
REQ-003 SHALL have parameter DEPTH, default 4, issue-queue entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_RETRY, default 2, replays allowed per nacked prefetch.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port pf_req_valid  input  1  prefetch candidate valid.
REQ-008 SHALL have port pf_req_ready  output  1  candidate accepted this cycle.
REQ-009 SHALL have port pf_req_addr  input  ADDR_BITS  candidate byte address.
REQ-010 SHALL have port pf_req_write  input  1  prefetch-for-write hint.
REQ-011 SHALL have port cpu_req_valid  input  1  core using dmem port this cycle (priority).
REQ-012 SHALL have port dmem_req_ready  input  1  dmem port accepts request.
REQ-013 SHALL have port dmem_req_valid  output  1  prefetch request valid.
REQ-014 SHALL have port dmem_req_addr  output  ADDR_BITS  line-aligned prefetch address.
REQ-015 SHALL have port dmem_req_write  output  1  write hint of issued entry.
REQ-016 SHALL have port dmem_nack  input  1  request fired two cycles earlier rejected.
REQ-017 SHALL have port occupancy  output  $clog2(DEPTH)+1  queued entries.
REQ-018 SHALL have port merge_count  output  16  candidates dropped as duplicates, saturating.
REQ-019 SHALL have port drop_count  output  16  prefetches abandoned after MAX_RETRY, saturating.

Function
REQ-020 SHALL store per entry: line = addr[ADDR_BITS-1:LINE_SHIFT], write bit, retry count; FIFO order.
REQ-021 SHALL track fired requests in 2-stage in-flight pipe s1->s2 (valid, line, write, retry); inflight = s1.v+s2.v.
REQ-022 SHALL drive pf_req_ready = (occupancy + inflight < DEPTH), combinational from state only; a slot is reserved for every in-flight replay.
REQ-023 SHALL treat candidate accepted (pf_req_valid & pf_req_ready) whose line equals a valid queue, s1 or s2 line as merged: not enqueued, merge_count+1.
REQ-024 SHALL otherwise enqueue accepted candidate at tail with retry=0.
REQ-025 SHALL drive dmem_req_valid = (occupancy!=0) & !cpu_req_valid; addr = {head.line, LINE_SHIFT zeros}; write = head.write.
REQ-026 SHALL on fire (dmem_req_valid & dmem_req_ready) dequeue head into s1; s1 moves to s2 and s2 retires every cycle.
REQ-027 SHALL sample dmem_nack only when s2 valid; nack with s2 invalid SHALL be ignored.
REQ-028 SHALL on s2 nack with retry<MAX_RETRY re-enqueue s2 entry at tail with retry+1 in that cycle.
REQ-029 SHALL on s2 nack with retry==MAX_RETRY discard entry and increment drop_count.
REQ-030 SHALL, when replay and new candidate enqueue in same cycle, write replay first then candidate (two tail slots); reservation guarantees space.
REQ-031 SHALL allow simultaneous enqueue, replay and dequeue in one cycle; occupancy updates by net change.
REQ-032 SHALL saturate merge_count and drop_count at 16'hFFFF.
REQ-033 SHALL keep dmem_req_valid low while cpu_req_valid high, with no queue state change other than enqueue/replay.

Reset
REQ-034 SHALL on reset clear queue, s1, s2, occupancy, merge_count, drop_count; dmem_req_valid=0, pf_req_ready=1 next cycle.
REQ-035 SHALL discard in-flight entries on reset mid-operation; nacks arriving after reset SHALL be ignored.

Verification
REQ-036 Enqueue 0x1000_0040 with dmem_req_ready=1, cpu_req_valid=0 -> dmem_req_valid next cycle, addr 0x1000_0040; no nack -> occupancy 0, counters 0.
REQ-037 Enqueue 0x2000_0004 then 0x2000_0038 -> second merged, merge_count=1, single request to 0x2000_0000.
REQ-038 Issue 0x3000_0000, assert dmem_nack 2 cycles after fire three times -> two reissues (retry 1,2), then drop_count=1, occupancy 0.
REQ-039 Fill DEPTH=4 distinct lines with dmem_req_ready=0 -> pf_req_ready=0 at occupancy 4; release one fire -> ready stays 0 until s2 retires.
REQ-040 Hold cpu_req_valid=1 with 2 queued entries -> dmem_req_valid=0 throughout; deassert -> head issues next cycle, FIFO order.
REQ-041 Reset 1 cycle after fire, nack on following cycle -> no replay, occupancy 0, drop_count 0.

Source files
------------

// File: rtl/l1_prefetch_issue_ctrl_if.sv
// Handshake bundle shared by the prefetch source, the issue controller and
// the dmem request port.
interface l1_prefetch_issue_ctrl_if #(
    parameter int ADDR_BITS = 40
);
    logic                 pf_req_valid;
    logic                 pf_req_ready;
    logic [ADDR_BITS-1:0] pf_req_addr;
    logic                 pf_req_write;
    logic                 cpu_req_valid;
    logic                 dmem_req_ready;
    logic                 dmem_req_valid;
    logic [ADDR_BITS-1:0] dmem_req_addr;
    logic                 dmem_req_write;
    logic                 dmem_nack;

    // Issue controller side: accepts candidates, drives prefetches to dmem.
    modport master (
        input  pf_req_valid, pf_req_addr, pf_req_write,
        input  cpu_req_valid, dmem_req_ready, dmem_nack,
        output pf_req_ready, dmem_req_valid, dmem_req_addr, dmem_req_write
    );

    // Environment side: prefetch source, core arbitration and dmem port.
    modport slave (
        output pf_req_valid, pf_req_addr, pf_req_write,
        output cpu_req_valid, dmem_req_ready, dmem_nack,
        input  pf_req_ready, dmem_req_valid, dmem_req_addr, dmem_req_write
    );
endinterface

// File: rtl/l1_prefetch_issue_ctrl.sv
// L1 prefetch issue controller: a small FIFO of line addresses that issues
// prefetches to the dmem port when the core leaves it idle, merges duplicate
// candidates, and replays nacked prefetches a bounded number of times.
module l1_prefetch_issue_ctrl #(
    parameter int ADDR_BITS  = 40,
    parameter int LINE_SHIFT = 6,
    parameter int DEPTH      = 4,
    parameter int MAX_RETRY  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    l1_prefetch_issue_ctrl_if.master bus,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              merge_count,
    output logic [15:0]              drop_count
);
    localparam int LINE_W = ADDR_BITS - LINE_SHIFT;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int RTY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Queue storage (no reset needed: validity comes from head/occupancy).
    logic [LINE_W-1:0] r_q_line  [DEPTH];
    logic              r_q_write [DEPTH];
    logic [RTY_W-1:0]  r_q_retry [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;

    // Two-stage in-flight tracker; s2 is the stage the nack refers to.
    logic              r_s1_v;
    logic [LINE_W-1:0] r_s1_line;
    logic              r_s1_write;
    logic [RTY_W-1:0]  r_s1_retry;
    logic              r_s2_v;
    logic [LINE_W-1:0] r_s2_line;
    logic              r_s2_write;
    logic [RTY_W-1:0]  r_s2_retry;

    logic [15:0]       r_merge_cnt;
    logic [15:0]       r_drop_cnt;

    logic [OCC_W-1:0]  w_inflight;
    logic              w_ready;
    logic [LINE_W-1:0] w_cand_line;
    logic [DEPTH-1:0]  w_entry_hit;
    logic              w_hit;
    logic              w_accept;
    logic              w_enq;
    logic              w_merge;
    logic              w_issue_valid;
    logic              w_fire;
    logic              w_nack;
    logic              w_replay;
    logic              w_drop;
    logic [PTR_W-1:0]  w_cand_slot;
    logic              w_unused_offset;

    // Byte offset within the line never matters for a line prefetch.
    assign w_unused_offset = ^bus.pf_req_addr[LINE_SHIFT-1:0];

    // Every in-flight request holds a reserved slot so its replay always fits.
    assign w_inflight  = OCC_W'(r_s1_v) + OCC_W'(r_s2_v);
    assign w_ready     = (r_occ + w_inflight) < OCC_W'(DEPTH);
    assign w_cand_line = bus.pf_req_addr[ADDR_BITS-1:LINE_SHIFT];

    // Duplicate detection against every live queue slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] w_dist;
            assign w_dist          = PTR_W'(gi) - r_head;
            assign w_entry_hit[gi] = ({1'b0, w_dist} < r_occ) &&
                                     (r_q_line[gi] == w_cand_line);
        end
    endgenerate

    assign w_hit = (|w_entry_hit) ||
                   (r_s1_v && (r_s1_line == w_cand_line)) ||
                   (r_s2_v && (r_s2_line == w_cand_line));

    assign w_accept      = bus.pf_req_valid && w_ready;
    assign w_enq         = w_accept && !w_hit;
    assign w_merge       = w_accept && w_hit;
    assign w_issue_valid = (r_occ != '0) && !bus.cpu_req_valid;
    assign w_fire        = w_issue_valid && bus.dmem_req_ready;
    assign w_nack        = r_s2_v && bus.dmem_nack;
    assign w_replay      = w_nack && (r_s2_retry < RTY_W'(MAX_RETRY));
    assign w_drop        = w_nack && !w_replay;
    // Replay takes the first free slot; a new candidate goes right behind it.
    assign w_cand_slot   = r_tail + PTR_W'(w_replay);

    assign bus.pf_req_ready   = w_ready;
    assign bus.dmem_req_valid = w_issue_valid;
    assign bus.dmem_req_addr  = {r_q_line[r_head], {LINE_SHIFT{1'b0}}};
    assign bus.dmem_req_write = r_q_write[r_head];

    assign occupancy   = r_occ;
    assign merge_count = r_merge_cnt;
    assign drop_count  = r_drop_cnt;

    // Write replayed and newly accepted entries into the tail slots.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_replay) begin
                r_q_line[r_tail]  <= r_s2_line;
                r_q_write[r_tail] <= r_s2_write;
                r_q_retry[r_tail] <= r_s2_retry + 1'b1;
            end
            if (w_enq) begin
                r_q_line[w_cand_slot]  <= w_cand_line;
                r_q_write[w_cand_slot] <= bus.pf_req_write;
                r_q_retry[w_cand_slot] <= '0;
            end
        end
    end

    // Pointers, occupancy, in-flight pipe and saturating statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_occ       <= '0;
            r_s1_v      <= 1'b0;
            r_s1_line   <= '0;
            r_s1_write  <= 1'b0;
            r_s1_retry  <= '0;
            r_s2_v      <= 1'b0;
            r_s2_line   <= '0;
            r_s2_write  <= 1'b0;
            r_s2_retry  <= '0;
            r_merge_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_head <= r_head + PTR_W'(w_fire);
            r_tail <= r_tail + PTR_W'(w_replay) + PTR_W'(w_enq);
            r_occ  <= r_occ + OCC_W'(w_enq) + OCC_W'(w_replay) - OCC_W'(w_fire);

            r_s1_v     <= w_fire;
            r_s1_line  <= r_q_line[r_head];
            r_s1_write <= r_q_write[r_head];
            r_s1_retry <= r_q_retry[r_head];

            r_s2_v     <= r_s1_v;
            r_s2_line  <= r_s1_line;
            r_s2_write <= r_s1_write;
            r_s2_retry <= r_s1_retry;

            if (w_merge && (r_merge_cnt != 16'hFFFF)) begin
                r_merge_cnt <= r_merge_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end
endmodule
